inst_encoder: RTL

INST_ENCODER -- requirements
Module: inst_encoder

---
 rtl/inst_encoder.sv | 89 ++++++++
 1 files changed

// File: rtl/inst_encoder.sv
// LEGv8 instruction encoder feeding a 4-entry FIFO with a running instruction-memory address.
// Define ENCODER_RANGE_CHECK_EN to drop (and flag) LDUR/STUR/CBZ requests whose immediate does not fit its field.
module inst_encoder (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  op,
  input  logic [4:0]  rd,
  input  logic [4:0]  rn,
  input  logic [4:0]  rm,
  input  logic [31:0] imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [5:0]  out_addr,
  output logic [2:0]  count,
  output logic        err
);

  logic [31:0] mem [4];
  logic [1:0]  wr_ptr;
  logic [1:0]  rd_ptr;
  logic [31:0] enc_word;
  logic        legal;
  logic        accept;
  logic        push;
  logic        pop;

  assign in_ready  = (count != 3'd4);
  assign out_valid = (count != 3'd0);
  assign accept    = in_valid && in_ready;
  assign push      = accept && legal;
  assign pop       = out_valid && out_ready;
  assign out_instr = out_valid ? mem[rd_ptr] : 32'h0000_0000;

  always_comb begin
    enc_word = 32'h0000_0000;
    legal    = 1'b1;
    case (op)
      3'd0:    enc_word = {11'b10001011000, rm, 6'b000000, rn, rd};
      3'd1:    enc_word = {11'b11001011000, rm, 6'b000000, rn, rd};
      3'd2:    enc_word = {11'b10001010000, rm, 6'b000000, rn, rd};
      3'd3:    enc_word = {11'b10101010000, rm, 6'b000000, rn, rd};
      3'd4:    enc_word = {11'b11111000010, imm[8:0], 2'b00, rn, rd};
      3'd5:    enc_word = {11'b11111000000, imm[8:0], 2'b00, rn, rd};
      3'd6:    enc_word = {8'b10110100, imm[18:0], rd};
      default: legal = 1'b0;
    endcase
`ifdef ENCODER_RANGE_CHECK_EN
    // An immediate fits a signed N-bit field only if every bit above it matches the field's sign bit.
    if ((op == 3'd4 || op == 3'd5) && (imm[31:8] != {24{imm[8]}}))
      legal = 1'b0;
    if ((op == 3'd6) && (imm[31:18] != {14{imm[18]}}))
      legal = 1'b0;
`endif
  end

`ifndef ENCODER_RANGE_CHECK_EN
  logic unused_imm_high;
  assign unused_imm_high = ^imm[31:19];
`endif

  // Storage needs no reset: an empty FIFO masks whatever the entries hold.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= enc_word;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= 2'd0;
      rd_ptr   <= 2'd0;
      count    <= 3'd0;
      out_addr <= 6'd0;
      err      <= 1'b0;
    end else begin
      err <= accept && !legal;
      if (push)
        wr_ptr <= wr_ptr + 2'd1;
      if (pop) begin
        rd_ptr   <= rd_ptr + 2'd1;
        out_addr <= out_addr + 6'd1;
      end
      count <= count + {2'b00, push} - {2'b00, pop};
    end
  end

endmodule
